// File: rtl/mem_bus_sched_if.sv
// Bundle of the IFU (m0), LSU (m1) and downstream AXI-lite (s) channels around the scheduler.
// The "master" modport is the scheduler's view; "slave" is the view of the masters/memory around it.
interface mem_bus_sched_if;
  logic [31:0] m0_araddr;
  logic        m0_arvalid;
  logic        m0_arready;
  logic [31:0] m0_rdata;
  logic [1:0]  m0_rresp;
  logic        m0_rvalid;
  logic        m0_rready;

  logic [31:0] m1_araddr;
  logic        m1_arvalid;
  logic        m1_arready;
  logic [31:0] m1_rdata;
  logic [1:0]  m1_rresp;
  logic        m1_rvalid;
  logic        m1_rready;
  logic [31:0] m1_awaddr;
  logic        m1_awvalid;
  logic        m1_awready;
  logic [31:0] m1_wdata;
  logic [7:0]  m1_wstrb;
  logic        m1_wvalid;
  logic        m1_wready;
  logic [1:0]  m1_bresp;
  logic        m1_bvalid;
  logic        m1_bready;

  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;
  logic [31:0] s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [7:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;

  modport master (
    input  m0_araddr, m0_arvalid, m0_rready,
    input  m1_araddr, m1_arvalid, m1_rready, m1_awaddr, m1_awvalid,
    input  m1_wdata, m1_wstrb, m1_wvalid, m1_bready,
    input  s_arready, s_rdata, s_rresp, s_rvalid, s_awready, s_wready, s_bresp, s_bvalid,
    output m0_arready, m0_rdata, m0_rresp, m0_rvalid,
    output m1_arready, m1_rdata, m1_rresp, m1_rvalid, m1_awready, m1_wready, m1_bresp, m1_bvalid,
    output s_araddr, s_arvalid, s_rready, s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready
  );

  modport slave (
    output m0_araddr, m0_arvalid, m0_rready,
    output m1_araddr, m1_arvalid, m1_rready, m1_awaddr, m1_awvalid,
    output m1_wdata, m1_wstrb, m1_wvalid, m1_bready,
    output s_arready, s_rdata, s_rresp, s_rvalid, s_awready, s_wready, s_bresp, s_bvalid,
    input  m0_arready, m0_rdata, m0_rresp, m0_rvalid,
    input  m1_arready, m1_rdata, m1_rresp, m1_rvalid, m1_awready, m1_wready, m1_bresp, m1_bvalid,
    input  s_araddr, s_arvalid, s_rready, s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready
  );
endinterface

// File: rtl/mem_bus_sched.sv
// Single-outstanding arbiter of IFU reads and LSU reads/writes onto one AXI-lite slave.
// Grant is a one-cycle ready pulse in IDLE; responses pass through combinationally; optional SLVERR timeout.
module mem_bus_sched #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic clk,
  input  logic rst,
  mem_bus_sched_if.master bus,
  output logic timeout_flag
);
  typedef enum logic [1:0] {IDLE, RD0, RD1, WR1} state_t;

  state_t      state;
  logic        last_m1;
  logic [7:0]  cnt;
  logic [7:0]  cnt_inc;
  logic        ar_vld;
  logic        aw_vld;
  logic        w_vld;
  logic [31:0] araddr_q;
  logic [31:0] awaddr_q;
  logic [31:0] wdata_q;
  logic [7:0]  wstrb_q;

  logic m1_wr_req, m1_req, gnt_m0, gnt_m1, gnt_wr, gnt_rd1;
  logic to_hit, m0_rv, m1_rv, m1_bv, resp_done;

  always_comb begin
    m1_wr_req = bus.m1_awvalid && bus.m1_wvalid;
    m1_req    = m1_wr_req || bus.m1_arvalid;
    // IFU wins a tie only if the LSU was granted last
    gnt_m0    = rst && (state == IDLE) && bus.m0_arvalid && (!m1_req || last_m1);
    gnt_m1    = rst && (state == IDLE) && m1_req && !gnt_m0;
    gnt_wr    = gnt_m1 && m1_wr_req;
    gnt_rd1   = gnt_m1 && !m1_wr_req;
    to_hit    = (TIMEOUT != 8'd0) && (state != IDLE) && (cnt == TIMEOUT);
    cnt_inc   = cnt + 8'd1;
    m0_rv     = rst && (state == RD0) && (to_hit || bus.s_rvalid);
    m1_rv     = rst && (state == RD1) && (to_hit || bus.s_rvalid);
    m1_bv     = rst && (state == WR1) && (to_hit || bus.s_bvalid);
    resp_done = (m0_rv && bus.m0_rready) || (m1_rv && bus.m1_rready) || (m1_bv && bus.m1_bready);
  end

  assign bus.m0_arready = gnt_m0;
  assign bus.m1_arready = gnt_rd1;
  assign bus.m1_awready = gnt_wr;
  assign bus.m1_wready  = gnt_wr;

  assign bus.m0_rvalid  = m0_rv;
  assign bus.m0_rdata   = to_hit ? 32'h0 : bus.s_rdata;
  assign bus.m0_rresp   = to_hit ? 2'b10 : bus.s_rresp;
  assign bus.m1_rvalid  = m1_rv;
  assign bus.m1_rdata   = to_hit ? 32'h0 : bus.s_rdata;
  assign bus.m1_rresp   = to_hit ? 2'b10 : bus.s_rresp;
  assign bus.m1_bvalid  = m1_bv;
  assign bus.m1_bresp   = to_hit ? 2'b10 : bus.s_bresp;

  // IDLE keeps both response readies high so stale slave responses are drained
  assign bus.s_rready = (state == IDLE) || ((state == RD0) && bus.m0_rready) ||
                        ((state == RD1) && bus.m1_rready);
  assign bus.s_bready = (state == IDLE) || ((state == WR1) && bus.m1_bready);

  assign bus.s_araddr  = araddr_q;
  assign bus.s_arvalid = ar_vld;
  assign bus.s_awaddr  = awaddr_q;
  assign bus.s_awvalid = aw_vld;
  assign bus.s_wdata   = wdata_q;
  assign bus.s_wstrb   = wstrb_q;
  assign bus.s_wvalid  = w_vld;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      last_m1      <= 1'b0;
      cnt          <= 8'h0;
      timeout_flag <= 1'b0;
      ar_vld       <= 1'b0;
      aw_vld       <= 1'b0;
      w_vld        <= 1'b0;
      araddr_q     <= 32'h0;
      awaddr_q     <= 32'h0;
      wdata_q      <= 32'h0;
      wstrb_q      <= 8'h0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 8'h0;
          if (gnt_m0) begin
            state    <= RD0;
            araddr_q <= bus.m0_araddr;
            ar_vld   <= 1'b1;
            last_m1  <= 1'b0;
          end else if (gnt_rd1) begin
            state    <= RD1;
            araddr_q <= bus.m1_araddr;
            ar_vld   <= 1'b1;
            last_m1  <= 1'b1;
          end else if (gnt_wr) begin
            state    <= WR1;
            awaddr_q <= bus.m1_awaddr;
            wdata_q  <= bus.m1_wdata;
            wstrb_q  <= bus.m1_wstrb;
            aw_vld   <= 1'b1;
            w_vld    <= 1'b1;
            last_m1  <= 1'b1;
          end
        end
        default: begin
          if (resp_done) begin
            // a response may beat the request handshake; drop any pending slave valids
            state  <= IDLE;
            cnt    <= 8'h0;
            ar_vld <= 1'b0;
            aw_vld <= 1'b0;
            w_vld  <= 1'b0;
          end else begin
            if (ar_vld && bus.s_arready) ar_vld <= 1'b0;
            if (aw_vld && bus.s_awready) aw_vld <= 1'b0;
            if (w_vld && bus.s_wready)   w_vld  <= 1'b0;
            if ((TIMEOUT == 8'd0) || (cnt != TIMEOUT)) cnt <= cnt_inc;
            // counter about to reach the limit: abandon the slave and arm the error response
            if ((TIMEOUT != 8'd0) && (cnt != TIMEOUT) && (cnt_inc == TIMEOUT)) begin
              timeout_flag <= 1'b1;
              ar_vld       <= 1'b0;
              aw_vld       <= 1'b0;
              w_vld        <= 1'b0;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_sched.sv
// Directed bench for mem_bus_sched: default-timeout instance for arbitration/data paths, TIMEOUT=4 instance for SLVERR.
module tb_mem_bus_sched;
  logic clk = 1'b0;
  logic rst;
  logic timeout_flag;
  logic timeout_flag2;
  int tests = 0;
  int fails = 0;

  mem_bus_sched_if bus ();
  mem_bus_sched_if bus2 ();

  mem_bus_sched dut (.clk(clk), .rst(rst), .bus(bus), .timeout_flag(timeout_flag));
  mem_bus_sched #(.TIMEOUT(8'd4)) dut_to (.clk(clk), .rst(rst), .bus(bus2), .timeout_flag(timeout_flag2));

  always #5 clk = ~clk;

  task tick;
    @(posedge clk);
    #2;
  endtask

  task clear_inputs;
    bus.m0_araddr = 0;  bus.m0_arvalid = 0; bus.m0_rready = 0;
    bus.m1_araddr = 0;  bus.m1_arvalid = 0; bus.m1_rready = 0;
    bus.m1_awaddr = 0;  bus.m1_awvalid = 0; bus.m1_wdata = 0; bus.m1_wstrb = 0;
    bus.m1_wvalid = 0;  bus.m1_bready = 0;
    bus.s_arready = 0;  bus.s_rdata = 0; bus.s_rresp = 0; bus.s_rvalid = 0;
    bus.s_awready = 0;  bus.s_wready = 0; bus.s_bresp = 0; bus.s_bvalid = 0;
    bus2.m0_araddr = 0; bus2.m0_arvalid = 0; bus2.m0_rready = 0;
    bus2.m1_araddr = 0; bus2.m1_arvalid = 0; bus2.m1_rready = 0;
    bus2.m1_awaddr = 0; bus2.m1_awvalid = 0; bus2.m1_wdata = 0; bus2.m1_wstrb = 0;
    bus2.m1_wvalid = 0; bus2.m1_bready = 0;
    bus2.s_arready = 0; bus2.s_rdata = 0; bus2.s_rresp = 0; bus2.s_rvalid = 0;
    bus2.s_awready = 0; bus2.s_wready = 0; bus2.s_bresp = 0; bus2.s_bvalid = 0;
  endtask

  task do_reset;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Completes an in-flight read in one cycle (address and data accepted together); drives only.
  task serve_read(input logic [31:0] d);
    bus.s_arready = 1; bus.s_rvalid = 1; bus.s_rdata = d; bus.s_rresp = 2'b00;
    tick();
    bus.s_arready = 0; bus.s_rvalid = 0; bus.s_rdata = 0;
  endtask

  task test_reset;
    rst = 1'b0;
    bus.m0_arvalid = 1; bus.m1_awvalid = 1; bus.m1_wvalid = 1;
    tick();
    tick();
    #1;
    tests++; if (bus.m0_arready !== 1'b0) begin fails++; $display("FAIL rst_m0_arready got=%b exp=0", bus.m0_arready); end
    tests++; if (bus.m1_awready !== 1'b0) begin fails++; $display("FAIL rst_m1_awready got=%b exp=0", bus.m1_awready); end
    tests++; if ({bus.s_arvalid, bus.s_awvalid, bus.s_wvalid} !== 3'b000) begin fails++; $display("FAIL rst_s_valids got=%b exp=000", {bus.s_arvalid, bus.s_awvalid, bus.s_wvalid}); end
    tests++; if (bus.s_araddr !== 32'h0 || bus.s_wdata !== 32'h0 || bus.s_wstrb !== 8'h0) begin fails++; $display("FAIL rst_regs got=%h/%h/%h exp=0", bus.s_araddr, bus.s_wdata, bus.s_wstrb); end
    tests++; if (timeout_flag !== 1'b0 || timeout_flag2 !== 1'b0) begin fails++; $display("FAIL rst_timeout_flag got=%b%b exp=00", timeout_flag, timeout_flag2); end
    tests++; if (bus.s_rready !== 1'b1 || bus.s_bready !== 1'b1) begin fails++; $display("FAIL rst_idle_readies got=%b%b exp=11", bus.s_rready, bus.s_bready); end
    clear_inputs();
    rst = 1'b1;
    tick();
  endtask

  task test_m0_read;
    bus.m0_araddr = 32'h8000_0000; bus.m0_arvalid = 1; bus.m0_rready = 1; bus.m1_rready = 1;
    #1;
    tests++; if (bus.m0_arready !== 1'b1 || bus.m1_arready !== 1'b0 || bus.m1_awready !== 1'b0) begin fails++; $display("FAIL rd_grant got=%b%b%b exp=100", bus.m0_arready, bus.m1_arready, bus.m1_awready); end
    tick();
    bus.m0_arvalid = 0; bus.s_arready = 1;
    #1;
    tests++; if (bus.s_arvalid !== 1'b1 || bus.s_araddr !== 32'h8000_0000) begin fails++; $display("FAIL rd_s_ar got=%b/%h exp=1/80000000", bus.s_arvalid, bus.s_araddr); end
    tick();
    bus.s_arready = 0; bus.s_rvalid = 1; bus.s_rdata = 32'h0000_0413; bus.s_rresp = 2'b00;
    #1;
    tests++; if (bus.s_arvalid !== 1'b0) begin fails++; $display("FAIL rd_arvalid_drop got=%b exp=0", bus.s_arvalid); end
    tests++; if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== 32'h0000_0413 || bus.m0_rresp !== 2'b00) begin fails++; $display("FAIL rd_m0_data got=%b/%h/%b exp=1/00000413/00", bus.m0_rvalid, bus.m0_rdata, bus.m0_rresp); end
    tests++; if (bus.m1_rvalid !== 1'b0 || bus.m1_bvalid !== 1'b0) begin fails++; $display("FAIL rd_m1_idle got=%b%b exp=00", bus.m1_rvalid, bus.m1_bvalid); end
    tick();
    bus.s_rvalid = 0;
    #1;
    tests++; if (bus.m0_rvalid !== 1'b0 || bus.s_bready !== 1'b1) begin fails++; $display("FAIL rd_back_idle got=%b/%b exp=0/1", bus.m0_rvalid, bus.s_bready); end
    clear_inputs();
  endtask

  task test_rr_tie;
    do_reset();
    bus.m0_araddr = 32'h100; bus.m1_araddr = 32'h200;
    bus.m0_arvalid = 1; bus.m1_arvalid = 1; bus.m0_rready = 1; bus.m1_rready = 1;
    #1;
    tests++; if (bus.m1_arready !== 1'b1 || bus.m0_arready !== 1'b0) begin fails++; $display("FAIL rr_first_tie got m1=%b m0=%b exp m1=1 m0=0", bus.m1_arready, bus.m0_arready); end
    tick();
    bus.m1_arvalid = 0;
    #1;
    tests++; if (bus.s_araddr !== 32'h200 || bus.m0_arready !== 1'b0) begin fails++; $display("FAIL rr_m1_addr got=%h/%b exp=200/0", bus.s_araddr, bus.m0_arready); end
    bus.s_arready = 1; bus.s_rvalid = 1; bus.s_rdata = 32'h22;
    #1;
    tests++; if (bus.m1_rvalid !== 1'b1 || bus.m1_rdata !== 32'h22 || bus.m0_rvalid !== 1'b0) begin fails++; $display("FAIL rr_m1_resp got=%b/%h/%b exp=1/22/0", bus.m1_rvalid, bus.m1_rdata, bus.m0_rvalid); end
    tick();
    bus.s_arready = 0; bus.s_rvalid = 0;
    #1;
    tests++; if (bus.m0_arready !== 1'b1) begin fails++; $display("FAIL rr_m0_second got=%b exp=1", bus.m0_arready); end
    tick();
    bus.m0_arvalid = 0;
    #1;
    tests++; if (bus.s_araddr !== 32'h100) begin fails++; $display("FAIL rr_m0_addr got=%h exp=100", bus.s_araddr); end
    serve_read(32'h11);
    bus.m0_arvalid = 1; bus.m1_arvalid = 1;
    #1;
    tests++; if (bus.m1_arready !== 1'b1 || bus.m0_arready !== 1'b0) begin fails++; $display("FAIL rr_after_m0 got m1=%b m0=%b exp m1=1 m0=0", bus.m1_arready, bus.m0_arready); end
    tick();
    bus.m1_arvalid = 0;
    serve_read(32'h33);
    bus.m1_arvalid = 1;
    #1;
    tests++; if (bus.m0_arready !== 1'b1 || bus.m1_arready !== 1'b0) begin fails++; $display("FAIL rr_after_m1 got m0=%b m1=%b exp m0=1 m1=0", bus.m0_arready, bus.m1_arready); end
    tick();
    bus.m0_arvalid = 0; bus.m1_arvalid = 0;
    serve_read(32'h44);
    clear_inputs();
  endtask

  task test_write;
    bus.m1_awaddr = 32'hA000_03F8; bus.m1_awvalid = 1;
    bus.m1_wdata = 32'h41; bus.m1_wstrb = 8'h01; bus.m1_wvalid = 1; bus.m1_bready = 1;
    #1;
    tests++; if (bus.m1_awready !== 1'b1 || bus.m1_wready !== 1'b1 || bus.m0_arready !== 1'b0) begin fails++; $display("FAIL wr_grant got=%b%b%b exp=110", bus.m1_awready, bus.m1_wready, bus.m0_arready); end
    tick();
    bus.m1_awvalid = 0; bus.m1_wvalid = 0; bus.s_wready = 1;
    #1;
    tests++; if (bus.s_awvalid !== 1'b1 || bus.s_wvalid !== 1'b1 || bus.s_awaddr !== 32'hA000_03F8) begin fails++; $display("FAIL wr_s_aw_w got=%b%b/%h exp=11/a00003f8", bus.s_awvalid, bus.s_wvalid, bus.s_awaddr); end
    tests++; if (bus.s_wdata !== 32'h41 || bus.s_wstrb !== 8'h01) begin fails++; $display("FAIL wr_s_data got=%h/%h exp=41/01", bus.s_wdata, bus.s_wstrb); end
    tick();
    bus.s_wready = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests++; if (bus.s_wvalid !== 1'b0 || bus.s_awvalid !== 1'b1) begin fails++; $display("FAIL wr_aw_hold%0d got w=%b aw=%b exp w=0 aw=1", i, bus.s_wvalid, bus.s_awvalid); end
      tick();
    end
    bus.s_awready = 1;
    #1;
    tests++; if (bus.s_awvalid !== 1'b1) begin fails++; $display("FAIL wr_aw_at_hs got=%b exp=1", bus.s_awvalid); end
    tick();
    bus.s_awready = 0; bus.s_bvalid = 1; bus.s_bresp = 2'b00;
    #1;
    tests++; if (bus.s_awvalid !== 1'b0) begin fails++; $display("FAIL wr_aw_drop got=%b exp=0", bus.s_awvalid); end
    tests++; if (bus.m1_bvalid !== 1'b1 || bus.m1_bresp !== 2'b00 || bus.s_bready !== 1'b1) begin fails++; $display("FAIL wr_bresp got=%b/%b/%b exp=1/00/1", bus.m1_bvalid, bus.m1_bresp, bus.s_bready); end
    tick();
    bus.s_bvalid = 0;
    #1;
    tests++; if (bus.m1_bvalid !== 1'b0 || timeout_flag !== 1'b0) begin fails++; $display("FAIL wr_done got=%b/%b exp=0/0", bus.m1_bvalid, timeout_flag); end
    clear_inputs();
  endtask

  task test_aw_only;
    bus.m1_awaddr = 32'h40; bus.m1_awvalid = 1; bus.m1_wvalid = 0; bus.m1_bready = 1;
    bus.m0_araddr = 32'h300; bus.m0_arvalid = 1; bus.m0_rready = 1;
    #1;
    tests++; if (bus.m0_arready !== 1'b1 || bus.m1_awready !== 1'b0) begin fails++; $display("FAIL awonly_grant got m0=%b aw=%b exp m0=1 aw=0", bus.m0_arready, bus.m1_awready); end
    tick();
    bus.m0_arvalid = 0;
    serve_read(32'h5);
    #1;
    tests++; if (bus.m1_awready !== 1'b0 || bus.m1_wready !== 1'b0) begin fails++; $display("FAIL awonly_idle got=%b%b exp=00", bus.m1_awready, bus.m1_wready); end
    tick();
    bus.m1_wvalid = 1; bus.m1_wdata = 32'h77; bus.m1_wstrb = 8'hFF;
    #1;
    tests++; if (bus.m1_awready !== 1'b1 || bus.m1_wready !== 1'b1) begin fails++; $display("FAIL awonly_wrise got=%b%b exp=11", bus.m1_awready, bus.m1_wready); end
    tick();
    bus.m1_awvalid = 0; bus.m1_wvalid = 0; bus.s_bvalid = 1; bus.s_bresp = 2'b01;
    #1;
    tests++; if (bus.m1_bvalid !== 1'b1 || bus.m1_bresp !== 2'b01) begin fails++; $display("FAIL early_b got=%b/%b exp=1/01", bus.m1_bvalid, bus.m1_bresp); end
    tick();
    bus.s_bvalid = 0;
    #1;
    tests++; if (bus.s_awvalid !== 1'b0 || bus.s_wvalid !== 1'b0) begin fails++; $display("FAIL early_b_clear got=%b%b exp=00", bus.s_awvalid, bus.s_wvalid); end
    clear_inputs();
  endtask

  task test_discard;
    bus.m0_rready = 1; bus.m1_rready = 1; bus.m1_bready = 1;
    bus.s_rvalid = 1; bus.s_bvalid = 1; bus.s_rdata = 32'hBAD;
    #1;
    tests++; if ({bus.m0_rvalid, bus.m1_rvalid, bus.m1_bvalid} !== 3'b000) begin fails++; $display("FAIL discard_fwd got=%b exp=000", {bus.m0_rvalid, bus.m1_rvalid, bus.m1_bvalid}); end
    tests++; if (bus.s_rready !== 1'b1 || bus.s_bready !== 1'b1) begin fails++; $display("FAIL discard_ready got=%b%b exp=11", bus.s_rready, bus.s_bready); end
    tick();
    clear_inputs();
  endtask

  task test_reset_mid;
    bus.m1_awaddr = 32'h80; bus.m1_awvalid = 1; bus.m1_wvalid = 1; bus.m1_bready = 1;
    tick();
    bus.m1_awvalid = 0; bus.m1_wvalid = 0;
    #1;
    tests++; if (bus.s_awvalid !== 1'b1) begin fails++; $display("FAIL midrst_pre got=%b exp=1", bus.s_awvalid); end
    rst = 1'b0; bus.s_bvalid = 1;
    #1;
    tests++; if (bus.m1_bvalid !== 1'b0) begin fails++; $display("FAIL midrst_bvalid_in_rst got=%b exp=0", bus.m1_bvalid); end
    tick();
    rst = 1'b1;
    #1;
    tests++; if ({bus.s_awvalid, bus.s_wvalid, bus.s_arvalid, bus.m1_bvalid} !== 4'b0000) begin fails++; $display("FAIL midrst_valids got=%b exp=0000", {bus.s_awvalid, bus.s_wvalid, bus.s_arvalid, bus.m1_bvalid}); end
    bus.s_bvalid = 0; bus.m0_arvalid = 1; bus.m0_rready = 1;
    #1;
    tests++; if (bus.m0_arready !== 1'b1) begin fails++; $display("FAIL midrst_idle_grant got=%b exp=1", bus.m0_arready); end
    tick();
    bus.m0_arvalid = 0;
    serve_read(32'h9);
    clear_inputs();
  endtask

  task test_timeout;
    bus2.m0_araddr = 32'h1234; bus2.m0_arvalid = 1; bus2.m0_rready = 1;
    bus2.s_rdata = 32'hDEAD_BEEF; bus2.s_rresp = 2'b00;
    #1;
    tests++; if (bus2.m0_arready !== 1'b1) begin fails++; $display("FAIL to_grant got=%b exp=1", bus2.m0_arready); end
    tick();
    bus2.m0_arvalid = 0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      tests++; if (bus2.m0_rvalid !== 1'b0 || bus2.s_arvalid !== 1'b1 || timeout_flag2 !== 1'b0) begin fails++; $display("FAIL to_wait%0d got rv=%b arv=%b flag=%b exp 0/1/0", i, bus2.m0_rvalid, bus2.s_arvalid, timeout_flag2); end
      tick();
    end
    #1;
    tests++; if (bus2.m0_rvalid !== 1'b1 || bus2.m0_rresp !== 2'b10 || bus2.m0_rdata !== 32'h0) begin fails++; $display("FAIL to_slverr got=%b/%b/%h exp=1/10/00000000", bus2.m0_rvalid, bus2.m0_rresp, bus2.m0_rdata); end
    tests++; if (bus2.s_arvalid !== 1'b0 || timeout_flag2 !== 1'b1) begin fails++; $display("FAIL to_flag got arv=%b flag=%b exp 0/1", bus2.s_arvalid, timeout_flag2); end
    tests++; if (bus2.m1_rvalid !== 1'b0 || bus2.m1_bvalid !== 1'b0) begin fails++; $display("FAIL to_other got=%b%b exp=00", bus2.m1_rvalid, bus2.m1_bvalid); end
    tick();
    tick();
    #1;
    tests++; if (bus2.m0_rvalid !== 1'b0 || timeout_flag2 !== 1'b1) begin fails++; $display("FAIL to_sticky got rv=%b flag=%b exp 0/1", bus2.m0_rvalid, timeout_flag2); end
    tests++; if (timeout_flag !== 1'b0) begin fails++; $display("FAIL main_no_timeout got=%b exp=0", timeout_flag); end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    test_reset();
    test_m0_read();
    test_rr_tie();
    test_write();
    test_aw_only();
    test_discard();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
